// File: rtl/uart_tx_engine_if.sv
// Write-side handshake bundle for uart_tx_engine.
// The register file drives the master side and the engine is the slave.
interface uart_tx_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine.
// A write FIFO feeds a frame FSM (start, data LSB first, optional parity,
// one or two stop bits). Divisor, parity mode and stop-bit count are latched
// when a word is popped, so every frame uses one consistent configuration.
// tx_o, done_o and break_o are registered copies of the FSM's decoded line
// state, so they trail the FSM state register by one cycle.
// Optional feature: define UART_TX_BREAK_EN to add break_i/break_o and the
// BREAK / MAB (mark-after-break) states.
module uart_tx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic [DIV_WIDTH-1:0]        divisor_i,
  input  logic [1:0]                  parity_mode_i,
  input  logic                        stop_bits_i,
  uart_tx_engine_if.slave             wr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        fifo_empty_o,
  output logic                        tx_o,
  output logic                        idle_o,
`ifdef UART_TX_BREAK_EN
  input  logic                        break_i,
  output logic                        break_o,
`endif
  output logic                        done_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] ST_BREAK  = 3'd5;
  localparam logic [2:0] ST_MAB    = 3'd6;
`endif

  // Parity over the data bits: even mode sends the XOR, odd mode its inverse.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                       input logic [1:0]            mode);
    return (^d) ^ (mode == 2'b10);
  endfunction

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_n;
  logic                  ready_q;
  logic                  empty_q;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  // Frame FSM state, per-frame configuration and datapath
  logic [2:0]            state_q;
  logic [2:0]            state_n;
  logic [DIV_WIDTH-1:0]  bit_cnt_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [1:0]            par_mode_q;
  logic                  stop2_q;
  logic                  par_bit_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [IDX_W-1:0]      data_idx_q;
  logic                  stop_idx_q;
  logic                  bit_end;
  logic                  start_ok;
  logic                  par_en;
  logic                  last_stop;
  logic                  done_c;
  logic                  tx_c;
  logic                  brk_enter;

  // Readiness is registered, so a pop in the same cycle cannot make room
  // for a write to a full FIFO.
  assign push    = wr.wr_valid && ready_q;
  assign head    = fifo_mem[rd_ptr];
  assign count_n = count_q + CW'(push) - CW'(pop);

  assign wr.wr_ready  = ready_q;
  assign fifo_count_o = count_q;
  assign fifo_empty_o = empty_q;
  assign idle_o       = (state_q == ST_IDLE);

  assign bit_end   = (bit_cnt_q == div_q);
  assign start_ok  = enable_i && !empty_q;
  assign par_en    = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
  assign last_stop = (stop_idx_q == stop2_q);

  // FIFO storage write; contents are never reset, the pointers define validity
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wr.wr_data;
    end
  end

  // FIFO pointers, occupancy and the registered full/empty flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      empty_q <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_n;
      ready_q <= (count_n != CW'(FIFO_DEPTH));
      empty_q <= (count_n == '0);
    end
  end

  // Next-state decode; a pop always coincides with entering START
  always_comb begin
    state_n   = state_q;
    pop       = 1'b0;
    done_c    = 1'b0;
    brk_enter = 1'b0;
    case (state_q)
      ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_i) begin
          state_n   = ST_BREAK;
          brk_enter = 1'b1;
        end else
`endif
        if (start_ok) begin
          state_n = ST_START;
          pop     = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end && (data_idx_q == IDX_W'(DATA_WIDTH - 1))) begin
          state_n = par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end && last_stop) begin
          done_c = 1'b1;
`ifdef UART_TX_BREAK_EN
          if (break_i) begin
            state_n   = ST_BREAK;
            brk_enter = 1'b1;
          end else
`endif
          if (start_ok) begin
            state_n = ST_START;
            pop     = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (!break_i) begin
          state_n = ST_MAB;
        end
      end
      ST_MAB: begin
        if (bit_end) begin
          if (break_i) begin
            state_n   = ST_BREAK;
            brk_enter = 1'b1;
          end else if (start_ok) begin
            state_n = ST_START;
            pop     = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
`endif
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Line level implied by the current FSM state
  always_comb begin
    tx_c = 1'b1;
    case (state_q)
      ST_START:  tx_c = 1'b0;
      ST_DATA:   tx_c = shreg_q[0];
      ST_PARITY: tx_c = par_bit_q;
`ifdef UART_TX_BREAK_EN
      ST_BREAK:  tx_c = 1'b0;
`endif
      default:   tx_c = 1'b1;
    endcase
  end

  // FSM state and bit-period counter; the counter restarts on every bit and
  // every state change, so it always runs 0..div_q within one bit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q <= state_n;
      if ((state_q == ST_IDLE) || (state_n != state_q) || bit_end) begin
        bit_cnt_q <= '0;
      end else begin
        bit_cnt_q <= bit_cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  // Per-frame configuration latch, captured only when a frame (or break) begins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q      <= '0;
      par_mode_q <= 2'b00;
      stop2_q    <= 1'b0;
    end else begin
      if (pop || brk_enter) begin
        div_q <= divisor_i;
      end
      if (pop) begin
        par_mode_q <= parity_mode_i;
        stop2_q    <= stop_bits_i;
      end
    end
  end

  // Data/stop bit position within the frame
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_idx_q <= '0;
      stop_idx_q <= 1'b0;
    end else begin
      if (state_q != ST_DATA) begin
        data_idx_q <= '0;
      end else if (bit_end) begin
        data_idx_q <= data_idx_q + IDX_W'(1);
      end
      if (state_q != ST_STOP) begin
        stop_idx_q <= 1'b0;
      end else if (bit_end && (state_n == ST_STOP)) begin
        stop_idx_q <= 1'b1;
      end
    end
  end

  // Shift register and parity bit, loaded from the FIFO head on pop
  always_ff @(posedge clk_i) begin
    if (pop) begin
      shreg_q   <= head;
      par_bit_q <= calc_parity(head, parity_mode_i);
    end else if ((state_q == ST_DATA) && bit_end) begin
      shreg_q <= shreg_q >> 1;
    end
  end

  // Registered serial outputs; reset forces an idle-high line and no pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_o    <= 1'b1;
      done_o  <= 1'b0;
`ifdef UART_TX_BREAK_EN
      break_o <= 1'b0;
`endif
    end else begin
      tx_o    <= tx_c;
      done_o  <= done_c;
`ifdef UART_TX_BREAK_EN
      break_o <= (state_q == ST_BREAK);
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine (DATA_WIDTH=8, FIFO_DEPTH=4).
// Expected line waveforms come from a frame model built from bit positions.
module tb_uart_tx_engine;
  localparam int W    = 8;
  localparam int DEPTH = 4;
  localparam int DIVW = 16;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic [DIVW-1:0] divisor;
  logic [1:0] pmode;
  logic sb;
  logic [$clog2(DEPTH):0] fifo_count;
  logic fifo_empty, tx, idle, done;
`ifdef UART_TX_BREAK_EN
  logic brk_in, brk_out;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_engine_if #(.DATA_WIDTH(W)) wr_if();

  uart_tx_engine #(.DATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .enable_i(enable),
    .divisor_i(divisor),
    .parity_mode_i(pmode),
    .stop_bits_i(sb),
    .wr(wr_if),
    .fifo_count_o(fifo_count),
    .fifo_empty_o(fifo_empty),
    .tx_o(tx),
    .idle_o(idle),
`ifdef UART_TX_BREAK_EN
    .break_i(brk_in),
    .break_o(brk_out),
`endif
    .done_o(done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int frame_len(input int div, input int pm, input int s);
    return (1 + W + ((pm == 1 || pm == 2) ? 1 : 0) + (s != 0 ? 2 : 1)) * (div + 1);
  endfunction

  // Line level at a given cycle offset from the start-bit edge
  function automatic logic exp_tx(input logic [W-1:0] d, input int div,
                                  input int pm, input int off);
    int b;
    b = off / (div + 1);
    if (b == 0) return 1'b0;
    if (b <= W) return d[b-1];
    if ((pm == 1 || pm == 2) && (b == W + 1)) return (^d) ^ (pm == 2);
    return 1'b1;
  endfunction

  task automatic write_word(input logic [W-1:0] d, output int acc);
    int n;
    n = 0;
    while (!wr_if.wr_ready && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("wr_ready_timeout", 0, 1);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    tick();
    acc = cyc;
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic mon_frame(input logic [W-1:0] d, input int div, input int pm,
                           input int s, input string tag,
                           output int start_c, output int done_c,
                           output int par_seen);
    int n;
    int len;
    n = 0;
    start_c = -1;
    done_c = -1;
    par_seen = -1;
    while (tx !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      chk({tag, "_start_timeout"}, 0, 1);
      return;
    end
    start_c = cyc;
    len = frame_len(div, pm, s);
    for (int off = 0; off < len; off++) begin
      if (off > 0) tick();
      chk({tag, "_tx"}, int'(tx), int'(exp_tx(d, div, pm, off)));
      chk({tag, "_done"}, int'(done), int'(off == len - 1));
      if (off == (1 + W) * (div + 1)) par_seen = int'(tx);
      if (done) done_c = cyc;
    end
  endtask

  initial begin
    int acc, acc2, s, d, p, prev_d, lows, dones;
    logic [W-1:0] d5 [5];
    logic [W-1:0] rd [4];
    int rdiv, rpm, rsb, k;

    rst = 1'b1;
    enable = 1'b0;
    divisor = 16'd3;
    pmode = 2'b00;
    sb = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data = '0;
`ifdef UART_TX_BREAK_EN
    brk_in = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_tx", int'(tx), 1);
    chk("rst_ready", int'(wr_if.wr_ready), 1);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_empty", int'(fifo_empty), 1);
    chk("rst_idle", int'(idle), 1);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    tick();

    // 0xA5, divisor 3, no parity, one stop bit: cycle-exact latency
    enable = 1'b1;
    fork
      write_word(8'hA5, acc);
      mon_frame(8'hA5, 3, 0, 0, "a5", s, d, p);
    join
    chk("a5_start_lat", s - acc, 2);
    chk("a5_done_lat", d - acc, 41);
    tick();
    chk("a5_idle_after", int'(idle), 1);
    chk("a5_tx_after", int'(tx), 1);

    // Even parity on 0x07
    pmode = 2'b01;
    fork
      write_word(8'h07, acc);
      mon_frame(8'h07, 3, 1, 0, "even", s, d, p);
    join
    chk("even_par_bit", p, 1);

    // Odd parity on 0x07 with two stop bits
    pmode = 2'b10;
    sb = 1'b1;
    fork
      write_word(8'h07, acc);
      mon_frame(8'h07, 3, 2, 1, "odd2", s, d, p);
    join
    chk("odd_par_bit", p, 0);
    chk("odd2_len", d - s + 1, 48);
    repeat (3) tick();

    // Fill the FIFO with enable low; the fifth write is dropped
    pmode = 2'b00;
    sb = 1'b0;
    enable = 1'b0;
    d5 = '{8'h11, 8'hC3, 8'h5A, 8'hFE, 8'h99};
    for (int i = 0; i < 5; i++) begin
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data = d5[i];
      tick();
      if (i == 0) chk("fill_count1", int'(fifo_count), 1);
      if (i == 3) begin
        chk("full_count", int'(fifo_count), 4);
        chk("full_ready", int'(wr_if.wr_ready), 0);
      end
    end
    wr_if.wr_valid = 1'b0;
    chk("drop_count", int'(fifo_count), 4);
    chk("drop_idle", int'(idle), 1);
    enable = 1'b1;
    prev_d = 0;
    for (int f = 0; f < 4; f++) begin
      mon_frame(d5[f], 3, 0, 0, "fifo", s, d, p);
      if (f > 0) chk("fifo_b2b_gap", s - prev_d, 1);
      prev_d = d;
    end
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!tx) lows++;
    end
    chk("no_fifth_frame", lows, 0);
    chk("fifo_empty_end", int'(fifo_empty), 1);

    // Divisor changed mid-frame affects only the next frame
    fork
      begin
        write_word(8'h3C, acc);
        write_word(8'h81, acc2);
        repeat (15) tick();
        divisor = 16'd7;
      end
      begin
        mon_frame(8'h3C, 3, 0, 0, "div3", s, d, p);
        prev_d = d;
        mon_frame(8'h81, 7, 0, 0, "div7", s, d, p);
        chk("div_b2b_gap", s - prev_d, 1);
        chk("div7_len", d - s + 1, 80);
      end
    join
    divisor = 16'd3;
    repeat (3) tick();

    // Reset during data bit 3 abandons the frame and flushes the FIFO
    write_word(8'hF0, acc);
    write_word(8'h0F, acc2);
    lows = 0;
    while (tx !== 1'b0 && lows < 50) begin
      tick();
      lows++;
    end
    chk("rstmid_started", int'(tx), 0);
    repeat (17) tick();
    rst = 1'b1;
    tick();
    chk("rstmid_tx", int'(tx), 1);
    chk("rstmid_idle", int'(idle), 1);
    chk("rstmid_count", int'(fifo_count), 0);
    chk("rstmid_empty", int'(fifo_empty), 1);
    chk("rstmid_ready", int'(wr_if.wr_ready), 1);
    chk("rstmid_done", int'(done), 0);
    rst = 1'b0;
    lows = 0;
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (!tx) lows++;
      if (done) dones++;
    end
    chk("rstmid_no_done", dones, 0);
    chk("rstmid_quiet", lows, 0);

    // Randomised configurations with back-to-back bursts
    for (int r = 0; r < 6; r++) begin
      rdiv = int'($urandom_range(0, 4));
      rpm = int'($urandom_range(0, 3));
      rsb = int'($urandom_range(0, 1));
      k = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) rd[i] = W'($urandom);
      divisor = DIVW'(rdiv);
      pmode = 2'(rpm);
      sb = rsb[0];
      fork
        begin
          for (int i = 0; i < k; i++) write_word(rd[i], acc);
        end
        begin
          for (int i = 0; i < k; i++) begin
            mon_frame(rd[i], rdiv, rpm, rsb, "rnd", s, d, p);
            if (i > 0) chk("rnd_b2b_gap", s - prev_d, 1);
            prev_d = d;
          end
        end
      join
      repeat (4) tick();
      chk("rnd_idle", int'(idle), 1);
    end

`ifdef UART_TX_BREAK_EN
    // Break held 20 cycles in IDLE with a word queued
    divisor = 16'd3;
    pmode = 2'b00;
    sb = 1'b0;
    begin
      logic txs [40];
      int a, lo, hi;
      brk_in = 1'b1;
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data = 8'h55;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (i == 0) wr_if.wr_valid = 1'b0;
        if (i == 10) chk("brk_out", int'(brk_out), 1);
        if (i == 19) brk_in = 1'b0;
        txs[i] = tx;
      end
      a = 0;
      while (a < 40 && txs[a]) a++;
      lo = 0;
      while (a < 40 && !txs[a]) begin lo++; a++; end
      hi = 0;
      while (a < 40 && txs[a]) begin hi++; a++; end
      chk("brk_low_len", lo, 20);
      chk("brk_mab_len", hi, 4);
      chk("brk_then_start", (a < 40) ? int'(txs[a]) : 1, 0);
    end
    repeat (60) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
